countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter HOURS_MAX, default 23, is the largest loadable hours value (BCD-validated against it).
REQ-002 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, synchronous and active-low.
REQ-004 tick  input  1  1 ms count enable, one clk_in cycle wide.
REQ-005 load  input  1  pulse; captures preset from Hours_i/Minutes_i/Seconds_i/milli_i.
REQ-006 start_stop  input  1  pulse; toggles RUN/PAUSED.
REQ-007 Hours_i, Minutes_i, Seconds_i  input  8 each  packed BCD preset, tens in [7:4], units in [3:0].
REQ-008 milli_i  input  12  3-digit BCD preset (hundreds [11:8], tens [7:4], units [3:0]).
REQ-009 Hours_o, Minutes_o, Seconds_o  output  8 each  remaining time, packed BCD, registered.
REQ-010 milli_o  output  12  remaining milliseconds, 3-digit BCD, registered.
REQ-011 running  output  1  high while in RUN.
REQ-012 expired  output  1  level, high while in EXPIRED.
REQ-013 expired_pulse  output  1  one-cycle pulse on entry to EXPIRED.
REQ-014 load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-015 FSM states: IDLE, RUN, PAUSED, EXPIRED.
REQ-016 Priority per edge: resetn low > load > start_stop > tick.
REQ-017 load accepted in any state if preset valid: every units digit <= 9, Seconds/Minutes tens <= 5, milli digits <= 9, hours value <= HOURS_MAX; count takes preset next edge, state -> IDLE, tick/start_stop same cycle ignored.
REQ-018 Invalid load: count and state unchanged, load_err = 1 for exactly next cycle.
REQ-019 start_stop in IDLE: -> RUN if count nonzero; ignored (stay IDLE) if count is all zero.
REQ-020 start_stop in RUN -> PAUSED; in PAUSED -> RUN; in EXPIRED ignored.
REQ-021 In RUN, each tick decrements the count by 1 ms, result visible on the following edge; tick ignored in IDLE, PAUSED, EXPIRED.
REQ-022 Borrow chain: digit at 0 wraps to its max (milli units/tens/hundreds 9, Seconds/Minutes units 9, tens 5, Hours units 9) and borrows from next digit; Hours decrement as 2-digit BCD (e.g. 10 -> 09).
REQ-023 Decrement that yields 00:00:00.000: same edge state -> EXPIRED, expired_pulse high for that one cycle, running low.
REQ-024 Count never decrements below zero; in EXPIRED outputs hold 00:00:00.000 until load or reset.
REQ-025 Leaving EXPIRED only via accepted load (-> IDLE) or reset.
REQ-026 start_stop and tick in same cycle in RUN: state -> PAUSED, no decrement; in PAUSED: state -> RUN, no decrement that cycle.
REQ-027 Outputs change only on clk_in edges; no combinational path input -> output.

Reset
REQ-028 resetn low at an edge: state IDLE, all count outputs 0, running 0, expired 0, expired_pulse 0, load_err 0; overrides load/tick/start_stop that cycle.
REQ-029 Reset mid-RUN or mid-EXPIRED returns to the REQ-028 state; preset is not retained.

Verification
REQ-030 load 00:00:01.000, start_stop, 1000 ticks -> count 00:00:00.000 after 1000th tick, expired_pulse exactly one cycle, expired held.
REQ-031 load 01:00:00.000, start_stop, 1 tick -> 00:59:59.999; running = 1.
REQ-032 load with Seconds_i = 8'h60 (or Hours_i = 8'h24 with HOURS_MAX 23) -> load_err pulse, prior count/state unchanged.
REQ-033 RUN at 00:00:00.005, start_stop and tick same cycle -> PAUSED, count stays 00:00:00.005; further ticks ignored; start_stop resumes decrement.
REQ-034 From all-zero IDLE, start_stop -> stays IDLE, running 0; load plus start_stop same cycle -> load wins, IDLE.
REQ-035 resetn low during RUN at 12:34:56.789 with tick high -> next cycle all outputs zero, IDLE.

Source files
------------

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - BCD hh:mm:ss.mmm countdown timer with load validation
module countdown_timer #(
    parameter int HOURS_MAX = 23
) (
    input  logic        clk_in,
    input  logic        resetn,
    input  logic        tick,
    input  logic        load,
    input  logic        start_stop,
    input  logic [7:0]  Hours_i,
    input  logic [7:0]  Minutes_i,
    input  logic [7:0]  Seconds_i,
    input  logic [11:0] milli_i,
    output logic [7:0]  Hours_o,
    output logic [7:0]  Minutes_o,
    output logic [7:0]  Seconds_o,
    output logic [11:0] milli_o,
    output logic        running,
    output logic        expired,
    output logic        expired_pulse,
    output logic        load_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    // Count is kept as nine BCD digits: {hh, mm, ss, mmm}, ms units in [3:0].
    state_t      state_q, state_d;
    logic [35:0] cnt_q, cnt_d;
    logic [35:0] cnt_dec;
    logic [35:0] preset;
    logic        pulse_q, pulse_d;
    logic        err_q, err_d;
    logic        preset_ok;
    logic        cnt_zero;
    logic        dec_zero;
    logic        borrow;
    logic [4:0]  dig_res;
    logic [7:0]  hours_val;

    // Returns {borrow_out, digit}; a zero digit under borrow wraps to its max.
    function automatic logic [4:0] dec_digit(input logic [3:0] d,
                                             input logic [3:0] max_val,
                                             input logic       borrow_in);
        if (!borrow_in) begin
            return {1'b0, d};
        end
        if (d == 4'd0) begin
            return {1'b1, max_val};
        end
        return {1'b0, d - 4'd1};
    endfunction

    // Tens of seconds and tens of minutes wrap to 5, every other digit to 9.
    function automatic logic [3:0] digit_max(input int idx);
        return ((idx == 4) || (idx == 6)) ? 4'd5 : 4'd9;
    endfunction

    assign preset    = {Hours_i, Minutes_i, Seconds_i, milli_i};
    assign hours_val = ({4'd0, Hours_i[7:4]} * 8'd10) + {4'd0, Hours_i[3:0]};

    // A preset is accepted only when every digit is legal BCD for its position.
    always_comb begin
        preset_ok = (Hours_i[7:4]   <= 4'd9) && (Hours_i[3:0]   <= 4'd9) &&
                    (hours_val      <= 8'(HOURS_MAX)) &&
                    (Minutes_i[7:4] <= 4'd5) && (Minutes_i[3:0] <= 4'd9) &&
                    (Seconds_i[7:4] <= 4'd5) && (Seconds_i[3:0] <= 4'd9) &&
                    (milli_i[11:8]  <= 4'd9) && (milli_i[7:4]   <= 4'd9) &&
                    (milli_i[3:0]   <= 4'd9);
    end

    // One-millisecond decrement rippling a borrow from ms units up to hours tens.
    always_comb begin
        cnt_dec = cnt_q;
        borrow  = 1'b1;
        dig_res = 5'd0;
        for (int i = 0; i < 9; i++) begin
            dig_res            = dec_digit(cnt_q[i*4 +: 4], digit_max(i), borrow);
            cnt_dec[i*4 +: 4]  = dig_res[3:0];
            borrow             = dig_res[4];
        end
    end

    assign cnt_zero = (cnt_q == 36'd0);
    assign dec_zero = (cnt_dec == 36'd0);

    // Next state / count: load beats start_stop, which beats tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            if (preset_ok) begin
                cnt_d   = preset;
                state_d = IDLE;
            end else begin
                err_d = 1'b1;
            end
        end else if (start_stop) begin
            case (state_q)
                IDLE:    state_d = cnt_zero ? IDLE : RUN;
                RUN:     state_d = PAUSED;
                PAUSED:  state_d = RUN;
                EXPIRED: state_d = EXPIRED;
                default: state_d = IDLE;
            endcase
        end else if (tick && (state_q == RUN)) begin
            // RUN always holds a nonzero count, so the borrow chain never underflows.
            cnt_d = cnt_dec;
            if (dec_zero) begin
                state_d = EXPIRED;
                pulse_d = 1'b1;
            end
        end
    end

    // State, count and the two one-cycle pulses; reset clears everything including the preset.
    always_ff @(posedge clk_in) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 36'd0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            err_q   <= err_d;
        end
    end

    assign Hours_o       = cnt_q[35:28];
    assign Minutes_o     = cnt_q[27:20];
    assign Seconds_o     = cnt_q[19:12];
    assign milli_o       = cnt_q[11:0];
    assign running       = (state_q == RUN);
    assign expired       = (state_q == EXPIRED);
    assign expired_pulse = pulse_q;
    assign load_err      = err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - vector table and scoreboard bench for countdown_timer
module tb_countdown_timer;

    logic        clk_in = 1'b0;
    logic        resetn;
    logic        tick;
    logic        load;
    logic        start_stop;
    logic [7:0]  Hours_i;
    logic [7:0]  Minutes_i;
    logic [7:0]  Seconds_i;
    logic [11:0] milli_i;
    logic [7:0]  Hours_o;
    logic [7:0]  Minutes_o;
    logic [7:0]  Seconds_o;
    logic [11:0] milli_o;
    logic        running;
    logic        expired;
    logic        expired_pulse;
    logic        load_err;

    always #5 clk_in = ~clk_in;

    countdown_timer #(.HOURS_MAX(23)) dut (
        .clk_in        (clk_in),
        .resetn        (resetn),
        .tick          (tick),
        .load          (load),
        .start_stop    (start_stop),
        .Hours_i       (Hours_i),
        .Minutes_i     (Minutes_i),
        .Seconds_i     (Seconds_i),
        .milli_i       (milli_i),
        .Hours_o       (Hours_o),
        .Minutes_o     (Minutes_o),
        .Seconds_o     (Seconds_o),
        .milli_o       (milli_o),
        .running       (running),
        .expired       (expired),
        .expired_pulse (expired_pulse),
        .load_err      (load_err)
    );

    typedef struct packed {
        logic [8*12-1:0] name;
        logic [35:0]     cnt;
        logic            run;
        logic            expd;
        logic            pulse;
        logic            err;
    } exp_t;

    typedef struct packed {
        logic        rstn;
        logic        ld;
        logic        ss;
        logic        tk;
        logic [35:0] preset;
        exp_t        exp;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [35:0] Z = 36'h0;

    function automatic vec_t mk(input logic [8*12-1:0] nm,
                                input logic rstn, input logic ld,
                                input logic ss, input logic tk,
                                input logic [35:0] preset,
                                input logic [35:0] cnt,
                                input logic run, input logic expd,
                                input logic pulse, input logic err);
        vec_t v;
        v.rstn      = rstn;
        v.ld        = ld;
        v.ss        = ss;
        v.tk        = tk;
        v.preset    = preset;
        v.exp.name  = nm;
        v.exp.cnt   = cnt;
        v.exp.run   = run;
        v.exp.expd  = expd;
        v.exp.pulse = pulse;
        v.exp.err   = err;
        return v;
    endfunction

    // Independent reference: integer milliseconds to nine packed BCD digits.
    function automatic logic [35:0] to_bcd(input int ms);
        int h, m, s, x;
        h = ms / 3600000;
        m = (ms / 60000) % 60;
        s = (ms / 1000) % 60;
        x = ms % 1000;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), 4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    task automatic drive(input vec_t v);
        @(negedge clk_in);
        resetn     = v.rstn;
        load       = v.ld;
        start_stop = v.ss;
        tick       = v.tk;
        Hours_i    = v.preset[35:28];
        Minutes_i  = v.preset[27:20];
        Seconds_i  = v.preset[19:12];
        milli_i    = v.preset[11:0];
        sb.push_back(v.exp);
    endtask

    // Scoreboard: each expectation queued at drive time is checked just after the next edge.
    always @(posedge clk_in) begin
        exp_t        e;
        logic [35:0] act;
        #1;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {Hours_o, Minutes_o, Seconds_o, milli_o};
            checks++;
            if ({act, running, expired, expired_pulse, load_err} !==
                {e.cnt, e.run, e.expd, e.pulse, e.err}) begin
                errors++;
                $display("FAIL %s: got cnt=%h run=%b expired=%b pulse=%b err=%b want cnt=%h run=%b expired=%b pulse=%b err=%b",
                         e.name, act, running, expired, expired_pulse, load_err,
                         e.cnt, e.run, e.expd, e.pulse, e.err);
            end
        end
    end

    initial begin
        resetn     = 1'b0;
        load       = 1'b0;
        start_stop = 1'b0;
        tick       = 1'b0;
        Hours_i    = 8'h0;
        Minutes_i  = 8'h0;
        Seconds_i  = 8'h0;
        milli_i    = 12'h0;

        //            name           rst ld ss tk preset         cnt            run exp pul err
        vecs.push_back(mk("reset",      0, 1, 1, 1, 36'h123456789, Z,             0, 0, 0, 0));
        vecs.push_back(mk("ss_zero",    1, 0, 1, 0, Z,             Z,             0, 0, 0, 0));
        vecs.push_back(mk("ld_1h",      1, 1, 0, 0, 36'h010000000, 36'h010000000, 0, 0, 0, 0));
        vecs.push_back(mk("ss_run",     1, 0, 1, 0, Z,             36'h010000000, 1, 0, 0, 0));
        vecs.push_back(mk("tick_1h",    1, 0, 0, 1, Z,             36'h005959999, 1, 0, 0, 0));
        vecs.push_back(mk("bad_sec",    1, 1, 0, 1, 36'h000060000, 36'h005959999, 1, 0, 0, 1));
        vecs.push_back(mk("err_clr",    1, 0, 0, 0, Z,             36'h005959999, 1, 0, 0, 0));
        vecs.push_back(mk("bad_hr24",   1, 1, 1, 0, 36'h240000000, 36'h005959999, 1, 0, 0, 1));
        vecs.push_back(mk("ld_23h",     1, 1, 1, 1, 36'h235959999, 36'h235959999, 0, 0, 0, 0));
        vecs.push_back(mk("bad_minu",   1, 1, 0, 0, 36'h005A00000, 36'h235959999, 0, 0, 0, 1));
        vecs.push_back(mk("bad_milli",  1, 1, 0, 0, 36'h0000009A0, 36'h235959999, 0, 0, 0, 1));
        vecs.push_back(mk("tick_idle",  1, 0, 0, 1, Z,             36'h235959999, 0, 0, 0, 0));
        vecs.push_back(mk("ss_run2",    1, 0, 1, 0, Z,             36'h235959999, 1, 0, 0, 0));
        vecs.push_back(mk("tick_23h",   1, 0, 0, 1, Z,             36'h235959998, 1, 0, 0, 0));
        vecs.push_back(mk("ld_ss_5ms",  1, 1, 1, 0, 36'h000000005, 36'h000000005, 0, 0, 0, 0));
        vecs.push_back(mk("ss_run3",    1, 0, 1, 0, Z,             36'h000000005, 1, 0, 0, 0));
        vecs.push_back(mk("ss_tk_pause",1, 0, 1, 1, Z,             36'h000000005, 0, 0, 0, 0));
        vecs.push_back(mk("tick_pause", 1, 0, 0, 1, Z,             36'h000000005, 0, 0, 0, 0));
        vecs.push_back(mk("tick_pause2",1, 0, 0, 1, Z,             36'h000000005, 0, 0, 0, 0));
        vecs.push_back(mk("ss_resume",  1, 0, 1, 0, Z,             36'h000000005, 1, 0, 0, 0));
        vecs.push_back(mk("tick_run",   1, 0, 0, 1, Z,             36'h000000004, 1, 0, 0, 0));
        vecs.push_back(mk("ss_pause",   1, 0, 1, 0, Z,             36'h000000004, 0, 0, 0, 0));
        vecs.push_back(mk("ss_tk_res",  1, 0, 1, 1, Z,             36'h000000004, 1, 0, 0, 0));
        vecs.push_back(mk("tick_run2",  1, 0, 0, 1, Z,             36'h000000003, 1, 0, 0, 0));
        vecs.push_back(mk("ld_10s",     1, 1, 0, 0, 36'h000010000, 36'h000010000, 0, 0, 0, 0));
        vecs.push_back(mk("ss_10s",     1, 0, 1, 0, Z,             36'h000010000, 1, 0, 0, 0));
        vecs.push_back(mk("tick_10s",   1, 0, 0, 1, Z,             36'h000009999, 1, 0, 0, 0));
        vecs.push_back(mk("ld_10h",     1, 1, 0, 0, 36'h100000000, 36'h100000000, 0, 0, 0, 0));
        vecs.push_back(mk("ss_10h",     1, 0, 1, 0, Z,             36'h100000000, 1, 0, 0, 0));
        vecs.push_back(mk("tick_10h",   1, 0, 0, 1, Z,             36'h095959999, 1, 0, 0, 0));
        vecs.push_back(mk("ld_12h",     1, 1, 0, 0, 36'h123456789, 36'h123456789, 0, 0, 0, 0));
        vecs.push_back(mk("ss_12h",     1, 0, 1, 0, Z,             36'h123456789, 1, 0, 0, 0));
        vecs.push_back(mk("tick_12h",   1, 0, 0, 1, Z,             36'h123456788, 1, 0, 0, 0));
        vecs.push_back(mk("rst_run",    0, 0, 1, 1, Z,             Z,             0, 0, 0, 0));
        vecs.push_back(mk("ld_2ms",     1, 1, 0, 0, 36'h000000002, 36'h000000002, 0, 0, 0, 0));
        vecs.push_back(mk("ss_2ms",     1, 0, 1, 0, Z,             36'h000000002, 1, 0, 0, 0));
        vecs.push_back(mk("tick_1ms",   1, 0, 0, 1, Z,             36'h000000001, 1, 0, 0, 0));
        vecs.push_back(mk("tick_exp",   1, 0, 0, 1, Z,             Z,             0, 1, 1, 0));
        vecs.push_back(mk("tick_exp2",  1, 0, 0, 1, Z,             Z,             0, 1, 0, 0));
        vecs.push_back(mk("ss_exp",     1, 0, 1, 0, Z,             Z,             0, 1, 0, 0));
        vecs.push_back(mk("bad_ld_exp", 1, 1, 0, 0, 36'h000060000, Z,             0, 1, 0, 1));
        vecs.push_back(mk("ld_exp",     1, 1, 0, 0, 36'h000000007, 36'h000000007, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i]);
        end

        // One-second run to expiry, checked against the integer-millisecond model.
        drive(mk("ld_1s", 1, 1, 0, 0, 36'h000001000, 36'h000001000, 0, 0, 0, 0));
        drive(mk("ss_1s", 1, 0, 1, 0, Z, 36'h000001000, 1, 0, 0, 0));
        for (int i = 1; i <= 1000; i++) begin
            drive(mk("tick_1s", 1, 0, 0, 1, Z, to_bcd(1000 - i),
                     (i < 1000), (i == 1000), (i == 1000), 1'b0));
        end
        for (int i = 0; i < 3; i++) begin
            drive(mk("exp_hold", 1, 0, 0, (i == 1), Z, Z, 0, 1, 0, 0));
        end
        drive(mk("rst_exp", 0, 0, 0, 0, Z, Z, 0, 0, 0, 0));
        drive(mk("ss_no_prst", 1, 0, 1, 0, Z, Z, 0, 0, 0, 0));
        drive(mk("idle_end", 1, 0, 0, 0, Z, Z, 0, 0, 0, 0));

        repeat (3) @(negedge clk_in);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
